// File: rtl/spi_frame_arbiter.sv
`timescale 1ns/1ps
// spi_frame_arbiter
// Shares one byte-level SPI shifter between NREQ requesters. Each granted
// requester gets one complete 8-byte frame: 7 payload bytes (byte 6 first)
// followed by a CRC-8 byte (poly 0x2F, seed 0xFF, MSB-first). The eight
// received bytes are checked with the same CRC and returned to the requester.
//
// Ports
//   clk, rst_b         : clock (rising edge), asynchronous active-low reset
//   req[NREQ]          : level request, held until the matching done bit
//   req_frame[56*NREQ] : payload of requester r at [56r +: 56]
//   gnt[NREQ]          : one-hot grant, frame start through the done cycle
//   done[NREQ]         : one-cycle end-of-frame pulse to the granted requester
//   rx_frame[64]       : received bytes, first byte at [63:56], CRC at [7:0]
//   crc_err            : final RX CRC was non-zero (valid with done)
//   frame_cnt[16]      : completed frames, wrapping
//   cs_b               : SPI chip select, active low
//   sh_start, sh_tx    : byte start strobe and byte to shift
//   sh_done, sh_rx     : byte complete strobe and received byte
//   fsm_state[3]       : current controller state, for observation
//
// Shifter handshake: sh_start is a single-cycle strobe issued only from SEND;
// sh_tx is held constant from that strobe until the matching sh_done. The
// shifter answers with exactly one single-cycle sh_done carrying sh_rx. There
// is never more than one byte outstanding, and sh_done seen in any state
// other than WAIT is ignored.
module spi_frame_arbiter #(
  parameter int NREQ     = 2,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [NREQ-1:0]      req,
  input  logic [56*NREQ-1:0]   req_frame,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [63:0]          rx_frame,
  output logic                 crc_err,
  output logic [15:0]          frame_cnt,
  output logic                 cs_b,
  output logic                 sh_start,
  output logic [7:0]           sh_tx,
  input  logic                 sh_done,
  input  logic [7:0]           sh_rx,
  output logic [2:0]           fsm_state
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SEND  = 3'd2,
    S_WAIT  = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] ptr, cur, pick;
  logic          pick_vld;
  logic [55:0]   pick_frame;
  logic [15:0]   tcnt;
  logic [2:0]    byte_idx;
  logic [55:0]   tx_shift;
  logic [63:0]   rx_shift;
  logic [7:0]    tx_crc, rx_crc;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h2F) : (c << 1);
    end
    return c;
  endfunction

  // Round-robin pick: walk from the highest offset down so the requester
  // closest to the pointer (in modular order) is the last one written.
  always_comb begin
    int cand;
    cand       = 0;
    pick       = ptr;
    pick_vld   = 1'b0;
    pick_frame = req_frame[55:0];
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (req[cand]) begin
        pick     = PW'(cand);
        pick_vld = 1'b1;
      end
    end
    for (int r = 0; r < NREQ; r++) begin
      if (pick == PW'(r)) pick_frame = req_frame[56*r +: 56];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pick_vld) state_nxt = S_SETUP;
      S_SETUP: if (tcnt == 16'(CS_SETUP - 1)) state_nxt = S_SEND;
      S_SEND:  state_nxt = S_WAIT;
      S_WAIT:  if (sh_done) state_nxt = (byte_idx == 3'd7) ? S_HOLD : S_SEND;
      S_HOLD:  if (tcnt == 16'(CS_HOLD - 1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= S_IDLE;
      ptr       <= '0;
      cur       <= '0;
      tcnt      <= '0;
      byte_idx  <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      tx_crc    <= 8'hFF;
      rx_crc    <= 8'hFF;
      rx_frame  <= '0;
      crc_err   <= 1'b0;
      frame_cnt <= '0;
      cs_b      <= 1'b1;
      sh_tx     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            cur      <= pick;
            tx_shift <= pick_frame;
            sh_tx    <= pick_frame[55:48];
            tx_crc   <= 8'hFF;
            rx_crc   <= 8'hFF;
            byte_idx <= '0;
            tcnt     <= '0;
            cs_b     <= 1'b0;
          end
        end
        S_SETUP: tcnt <= tcnt + 16'd1;
        S_SEND: begin
          // The CRC byte itself is not folded into the TX CRC.
          if (byte_idx != 3'd7) tx_crc <= crc8_byte(tx_crc, sh_tx);
        end
        S_WAIT: begin
          if (sh_done) begin
            rx_shift <= {rx_shift[55:0], sh_rx};
            rx_crc   <= crc8_byte(rx_crc, sh_rx);
            byte_idx <= byte_idx + 3'd1;
            tcnt     <= '0;
            tx_shift <= {tx_shift[47:0], 8'h00};
            // After payload byte 6 goes out, tx_crc already covers all seven.
            if (byte_idx == 3'd6)      sh_tx <= tx_crc;
            else if (byte_idx != 3'd7) sh_tx <= tx_shift[47:40];
          end
        end
        S_HOLD: begin
          tcnt <= tcnt + 16'd1;
          if (state_nxt == S_DONE) begin
            // Results and count are updated here so they are valid with done.
            rx_frame  <= rx_shift;
            crc_err   <= (rx_crc != 8'h00);
            frame_cnt <= frame_cnt + 16'd1;
            cs_b      <= 1'b1;
          end
        end
        S_DONE: ptr <= (int'(cur) == NREQ - 1) ? '0 : cur + 1'b1;
        default: ;
      endcase
    end
  end

  assign gnt       = (state != S_IDLE) ? (ONE << cur) : '0;
  assign done      = (state == S_DONE) ? (ONE << cur) : '0;
  assign sh_start  = (state == S_SEND);
  assign fsm_state = 3'(state);

endmodule

// File: tb/tb_spi_frame_arbiter.sv
`timescale 1ns/1ps
module tb_spi_frame_arbiter;

  localparam int NREQ     = 2;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;
  localparam int L        = 8;
  localparam int FRAME_LOW = CS_SETUP + 8 * (L + 2) + CS_HOLD;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req;
  logic [56*NREQ-1:0] req_frame;
  logic [NREQ-1:0]    gnt, done;
  logic [63:0]        rx_frame;
  logic               crc_err;
  logic [15:0]        frame_cnt;
  logic               cs_b, sh_start;
  logic [7:0]         sh_tx;
  logic               sh_done;
  logic [7:0]         sh_rx;
  logic [2:0]         fsm_state;

  spi_frame_arbiter #(.NREQ(NREQ), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
    .clk(clk), .rst_b(rst_b), .req(req), .req_frame(req_frame),
    .gnt(gnt), .done(done), .rx_frame(rx_frame), .crc_err(crc_err),
    .frame_cnt(frame_cnt), .cs_b(cs_b), .sh_start(sh_start), .sh_tx(sh_tx),
    .sh_done(sh_done), .sh_rx(sh_rx), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard ----------------
  logic [7:0]  exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_start;
  int          corrupt_idx = -1;
  logic [15:0] exp_cnt = 16'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Serial (bit-at-a-time) CRC-8, poly 0x2F.
  function automatic logic [7:0] crc_ser(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    logic fb;
    c = c_in;
    for (int b = 7; b >= 0; b--) begin
      fb = c[7] ^ d[b];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h2F : 8'h00);
    end
    return c;
  endfunction

  // ---------------- loopback shifter model ----------------
  initial begin : shifter
    logic [7:0] cap;
    int cnt;
    int idx;
    logic busy;
    busy = 1'b0; cnt = 0; idx = 0; cap = '0;
    sh_done = 1'b0; sh_rx = '0; n_start = 0;
    forever begin
      @(negedge clk);
      sh_done = 1'b0;
      if (!rst_b) begin
        busy = 1'b0;
      end else if (busy) begin
        cnt--;
        if (cnt == 0) begin
          busy = 1'b0;
          check("sh_tx_stable", 64'(sh_tx), 64'(cap));
          sh_rx   = cap ^ ((idx == corrupt_idx) ? 8'h01 : 8'h00);
          sh_done = 1'b1;
        end
      end else if (sh_start) begin
        cap  = sh_tx;
        idx  = n_start;
        n_start++;
        busy = 1'b1;
        cnt  = L + 1;
        if (exp_q.size() == 0) check("sh_tx_unexpected", 64'(cap), 64'hDEAD);
        else check("sh_tx", 64'(cap), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input int r);
    logic [55:0] p;
    logic [7:0]  c;
    p = req_frame[56*r +: 56];
    c = 8'hFF;
    for (int k = 0; k < 7; k++) begin
      exp_q.push_back(p[55-8*k -: 8]);
      c = crc_ser(c, p[55-8*k -: 8]);
    end
    exp_q.push_back(c);
  endtask

  // Expects requester r to be served next; caller holds req. Returns the
  // number of cs_b-high cycles seen before the fall.
  task automatic expect_frame(input int r, input int corrupt, input int drop_after, output int hi);
    logic [7:0]  b[8];
    logic [7:0]  c;
    logic [63:0] rx_exp;
    int low;
    bit ok;
    hi = 0;
    push_exp(r);
    for (int k = 0; k < 8; k++) b[k] = exp_q[exp_q.size() - 8 + k];
    if (corrupt >= 0) b[corrupt] = b[corrupt] ^ 8'h01;
    c = 8'hFF;
    rx_exp = '0;
    for (int k = 0; k < 8; k++) begin
      c = crc_ser(c, b[k]);
      rx_exp = {rx_exp[55:0], b[k]};
    end
    corrupt_idx = corrupt;
    n_start = 0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!cs_b) begin ok = 1; break; end
      hi++;
    end
    if (!ok) begin check("cs_fall_timeout", 64'd0, 64'd1); return; end
    low = 1;
    check("gnt_start", 64'(gnt), 64'd1 << r);
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (drop_after > 0 && n_start >= drop_after) req[r] = 1'b0;
      if (done != '0) begin ok = 1; break; end
      check("gnt_hold", 64'(gnt), 64'd1 << r);
      if (!cs_b) low++;
    end
    if (!ok) begin check("done_timeout", 64'd0, 64'd1); return; end
    exp_cnt = exp_cnt + 16'd1;
    check("done", 64'(done), 64'd1 << r);
    check("gnt_done", 64'(gnt), 64'd1 << r);
    check("cs_b_done", 64'(cs_b), 64'd1);
    check("cs_low_len", 64'(low), 64'(FRAME_LOW));
    check("rx_frame", rx_frame, rx_exp);
    check("crc_err", 64'(crc_err), 64'(c != 8'h00));
    check("frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    check("bytes_sent", 64'(n_start), 64'd8);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_cs_b"}, 64'(cs_b), 64'd1);
    check({pfx, "_gnt"}, 64'(gnt), 64'd0);
    check({pfx, "_done"}, 64'(done), 64'd0);
    check({pfx, "_rx_frame"}, rx_frame, 64'd0);
    check({pfx, "_crc_err"}, 64'(crc_err), 64'd0);
    check({pfx, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
    check({pfx, "_sh_start"}, 64'(sh_start), 64'd0);
    check({pfx, "_sh_tx"}, 64'(sh_tx), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int hi;
    int r;
    rst_b = 1'b0;
    req = '0;
    req_frame = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_b = 1'b1;
    @(negedge clk);

    // Single frame, known payload
    req_frame[55:0] = 56'h07060504030201;
    req = 2'b01;
    expect_frame(0, -1, 0, hi);
    req = '0;
    check("rx_payload", {8'h00, rx_frame[63:8]}, 64'h0007060504030201);
    check("crc_ok", 64'(crc_err), 64'd0);

    // RX corruption of received byte 3
    req = 2'b01;
    expect_frame(0, 3, 0, hi);
    req = '0;
    check("crc_bad", 64'(crc_err), 64'd1);

    // Request dropped after third byte start; pointer moves back to 0
    req_frame[111:56] = 56'({$urandom(), $urandom()});
    req = 2'b10;
    expect_frame(1, -1, 3, hi);
    req = '0;

    // Round-robin with both requests held
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      r = i % 2;
      expect_frame(r, -1, 0, hi);
      if (i > 0) check("cs_gap_ge2", 64'((hi + 1) >= 2), 64'd1);
      req_frame[56*r +: 56] = 56'({$urandom(), $urandom()});
    end
    req = '0;

    // Reset in the middle of the fifth byte
    repeat (2) @(negedge clk);
    req_frame[55:0] = 56'({$urandom(), $urandom()});
    req = 2'b01;
    push_exp(0);
    corrupt_idx = -1;
    n_start = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (n_start >= 5) break;
    end
    check("reach_byte5", 64'(n_start >= 5), 64'd1);
    @(posedge clk);
    #2;
    rst_b = 1'b0;
    #1;
    check_reset_vals("midrst");
    exp_q.delete();
    exp_cnt = 16'd0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    expect_frame(0, -1, 0, hi);
    req = '0;

    // Counter wrap
    @(negedge clk);
    force dut.frame_cnt = 16'hFFFE;
    #1;
    release dut.frame_cnt;
    exp_cnt = 16'hFFFE;
    req = 2'b01;
    expect_frame(0, -1, 0, hi);
    check("cnt_ffff", 64'(frame_cnt), 64'hFFFF);
    expect_frame(0, -1, 0, hi);
    check("cnt_wrap0", 64'(frame_cnt), 64'h0000);
    req = '0;

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
